// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetcher feeding a small
// in-order fetch queue. Redirects flush the queue and steer the PC; a
// response still in flight at redirect time is drained and dropped.
module fetch_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              FQ_DEPTH     = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_insn,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4,
  output logic            misalign_err
);

  localparam int            AW      = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FQ_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] insn;
  } fq_entry_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pend_pc;
  fq_entry_t       fq [FQ_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            grant, push, pop;

  // Request only when idle with room for the response; a redirect this
  // cycle withdraws the request so the stale PC is never granted.
  assign imem_req  = reset && (state == S_IDLE) && (count < DEPTH_C) && !redirect_valid;
  assign imem_addr = pc;
  assign grant     = imem_req && imem_gnt;

  // Redirect beats push and pop: the whole queue is discarded anyway.
  assign push = (state == S_WAIT) && imem_rvalid && !redirect_valid;
  assign pop  = out_valid && out_ready && !redirect_valid;

  assign out_valid    = (count != '0);
  assign out_pc       = fq[rd_ptr].pc;
  assign out_insn     = fq[rd_ptr].insn;
  assign out_pc_plus4 = out_pc + XLEN'(4);

  // Fetch FSM, PC and misalign flag; redirect overrides grant/response.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      pc           <= RESET_VECTOR;
      pend_pc      <= '0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= redirect_valid && (redirect_target[1:0] != 2'b00);
      if (redirect_valid) begin
        pc <= {redirect_target[XLEN-1:2], 2'b00};
        case (state)
          S_WAIT, S_DROP: state <= imem_rvalid ? S_IDLE : S_DROP;
          default:        state <= S_IDLE;
        endcase
      end else begin
        case (state)
          S_IDLE: if (grant) begin
            pend_pc <= pc;
            pc      <= pc + XLEN'(4);
            state   <= S_WAIT;
          end
          S_WAIT:  if (imem_rvalid) state <= S_IDLE;
          S_DROP:  if (imem_rvalid) state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Queue pointers and occupancy; a flush simply rewinds both pointers.
  always_ff @(posedge clk) begin
    if (!reset || redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Queue storage carries no reset; occupancy alone qualifies the head.
  always_ff @(posedge clk) begin
    if (reset && push) fq[wr_ptr] <= '{pc: pend_pc, insn: imem_rdata};
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a memory responder plus a transaction
// level model of the fetch stream; a monitor checks the queue head.
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_insn;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        misalign_err;

  fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .FQ_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn),
    .out_pc(out_pc), .out_pc_plus4(out_pc_plus4), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
  } ent_t;

  ent_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: what the fetch stream should look like, not how.
  logic [31:0] m_pc      = 32'h0;
  logic [31:0] m_pend    = 32'h0;
  bit          m_outst   = 1'b0;
  bit          m_discard = 1'b0;
  bit          m_mis     = 1'b0;
  int          m_cnt     = 0;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 4))
      0: return 32'h0000_0100;
      1: return 32'h0000_0202;
      2: return 32'hFFFF_FFFC;
      3: return 32'hFFFF_FFF8;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: queue head must match the oldest accepted fetch.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== (sb.size() != 0)) begin
        errors++;
        $display("FAIL out_valid got %0b exp %0b", out_valid, sb.size() != 0);
      end
      if (out_valid === 1'b1 && out_ready && sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if (out_pc !== e.pc || out_insn !== e.insn || out_pc_plus4 !== e.pc + 32'd4) begin
          errors++;
          $display("FAIL head got pc=%h insn=%h pc4=%h exp pc=%h insn=%h pc4=%h",
                   out_pc, out_insn, out_pc_plus4, e.pc, e.insn, e.pc + 32'd4);
        end
      end
    end
  end

  // Check request outputs, then advance the model across the next edge.
  task automatic model_step();
    bit exp_req, pop_now;
    exp_req = reset && !m_outst && (m_cnt < DEPTH) && !redirect_valid;
    checks++;
    if (imem_req !== exp_req) begin
      errors++;
      $display("FAIL imem_req got %0b exp %0b", imem_req, exp_req);
    end
    if (exp_req) begin
      checks++;
      if (imem_addr !== m_pc) begin
        errors++;
        $display("FAIL imem_addr got %h exp %h", imem_addr, m_pc);
      end
    end
    checks++;
    if (misalign_err !== m_mis) begin
      errors++;
      $display("FAIL misalign_err got %0b exp %0b", misalign_err, m_mis);
    end
    if (!reset) begin
      m_pc = 32'h0; m_outst = 0; m_discard = 0; m_mis = 0; m_cnt = 0;
      sb.delete();
    end else begin
      m_mis = redirect_valid && (redirect_target[1:0] != 2'b00);
      if (redirect_valid) begin
        m_pc  = redirect_target & 32'hFFFF_FFFC;
        m_cnt = 0;
        sb.delete();
        if (m_outst) begin
          if (imem_rvalid) begin m_outst = 0; m_discard = 0; end
          else m_discard = 1;
        end
      end else begin
        pop_now = (m_cnt != 0) && out_ready;
        if (pop_now) m_cnt--;
        if (exp_req && imem_gnt) begin
          m_outst = 1; m_discard = 0; m_pend = m_pc; m_pc = m_pc + 32'd4;
        end else if (m_outst && imem_rvalid) begin
          m_outst = 0;
          if (!m_discard) begin
            sb.push_back('{pc: m_pend, insn: imem_rdata});
            m_cnt++;
          end
          m_discard = 0;
        end
      end
    end
  endtask

  // One phase of random traffic; probabilities are in percent.
  task automatic run_phase(input int n, input int p_gnt, input int p_rv, input int p_rdy,
                           input int p_redir, input int p_rst, input int p_stray);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset           = ($urandom_range(0, 99) >= p_rst);
      redirect_valid  = ($urandom_range(0, 99) < p_redir);
      redirect_target = pick_target();
      imem_gnt        = ($urandom_range(0, 99) < p_gnt);
      if (m_outst) begin
        imem_rvalid = ($urandom_range(0, 99) < p_rv);
        imem_rdata  = mem_f(m_pend);
      end else begin
        imem_rvalid = ($urandom_range(0, 99) < p_stray);
        imem_rdata  = $urandom;
      end
      out_ready = ($urandom_range(0, 99) < p_rdy);
      #2;
      model_step();
    end
  endtask

  initial begin
    reset = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; out_ready = 1'b0;
    run_phase(3,   0,   0,   0,   0, 100, 0);   // held in reset
    run_phase(60,  100, 100, 100, 0, 0,   0);   // streaming from reset vector
    run_phase(20,  100, 100, 0,   0, 0,   0);   // queue fills, fetch stalls
    run_phase(40,  100, 100, 100, 0, 0,   0);   // drain and resume in order
    run_phase(400, 70,  60,  60,  8, 2,   10);
    run_phase(400, 50,  50,  30,  20, 4,  20);
    run_phase(300, 90,  90,  80,  30, 1,  15);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
